// File: rtl/adaptive_filter_seq.sv
// Sequential adaptive FIR (LMS / sign-error / sign-sign): one MAC per cycle, out_valid TAPS+2 cycles after accept.
// Backpressure: in_ready is high only in IDLE; busy TAPS+2 cycles, or 2*TAPS+2 when adapting.
module adaptive_filter_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14,
    parameter int TAPS  = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            din,
    input  logic [WIDTH-1:0]            desired,
    input  logic [WIDTH-1:0]            step_size,
    input  logic [1:0]                  mode,
    input  logic                        adapt_en,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            dout,
    output logic [WIDTH-1:0]            error,
    output logic [TAPS-1:0][WIDTH-1:0]  weights,
    output logic                        sat_flag
);

    localparam int KW = $clog2(TAPS);
    localparam int AW = 2*WIDTH + KW;
    localparam logic signed [AW-1:0] SMAX = $signed({{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    localparam logic signed [AW-1:0] SMIN = $signed({{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

    typedef enum logic [1:0] {IDLE, MAC, ERR, UPD} state_t;

    state_t                       state;
    logic [KW-1:0]                k;
    logic [TAPS-1:0][WIDTH-1:0]   xline;
    logic signed [AW-1:0]         acc;
    logic [WIDTH-1:0]             desired_l;
    logic [WIDTH-1:0]             mu_l;
    logic [1:0]                   mode_l;
    logic                         adapt_l;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [AW-1:0] v);
        if (v > SMAX)      return SMAX[WIDTH-1:0];
        else if (v < SMIN) return SMIN[WIDTH-1:0];
        else               return v[WIDTH-1:0];
    endfunction

    function automatic logic ovf(input logic signed [AW-1:0] v);
        return (v > SMAX) || (v < SMIN);
    endfunction

    logic signed [WIDTH-1:0]   cur_x, cur_w, dout_n, err_n, g0, delta;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH:0]   me, gx;
    logic signed [WIDTH:0]     err_wide, mu_s, g, step2, addend;
    logic signed [WIDTH+1:0]   wsum;
    logic signed [AW-1:0]      acc_sh, me_sh, gx_sh, wsum_ext;
    logic dout_ov, err_ov, g_ov, d_ov, w_ov;
    logic e_pos, e_neg, x_pos, x_neg;

    always_comb begin
        cur_x    = $signed(xline[k]);
        cur_w    = $signed(weights[k]);
        prod     = (2*WIDTH)'(cur_w) * (2*WIDTH)'(cur_x);
        acc_sh   = acc >>> FRAC;
        dout_n   = sat(acc_sh);
        dout_ov  = ovf(acc_sh);
        err_wide = $signed({desired_l[WIDTH-1], desired_l}) - $signed({dout_n[WIDTH-1], dout_n});
        err_n    = sat(AW'(err_wide));
        err_ov   = ovf(AW'(err_wide));

        // Update terms use the registered error of the sample currently in UPD
        e_pos = ~error[WIDTH-1] & (|error);
        e_neg = error[WIDTH-1];
        x_pos = ~cur_x[WIDTH-1] & (|cur_x);
        x_neg = cur_x[WIDTH-1];
        mu_s  = $signed({1'b0, mu_l});
        me    = (2*WIDTH+1)'(mu_s) * (2*WIDTH+1)'($signed(error));
        me_sh = AW'(me) >>> FRAC;
        g0    = sat(me_sh);
        g_ov  = ovf(me_sh);
        case (mode_l)
            2'd0:    g = (WIDTH+1)'(g0);
            2'd1:    g = e_pos ? mu_s : (e_neg ? -mu_s : {(WIDTH+1){1'b0}});
            default: g = {(WIDTH+1){1'b0}};
        endcase
        gx    = (2*WIDTH+1)'(g) * (2*WIDTH+1)'(cur_x);
        gx_sh = AW'(gx) >>> FRAC;
        delta = sat(gx_sh);
        d_ov  = ovf(gx_sh);
        if ((e_pos && x_pos) || (e_neg && x_neg))      step2 = mu_s;
        else if ((e_pos && x_neg) || (e_neg && x_pos)) step2 = -mu_s;
        else                                           step2 = {(WIDTH+1){1'b0}};
        addend   = (mode_l == 2'd2) ? step2 : (WIDTH+1)'(delta);
        wsum     = (WIDTH+2)'(cur_w) + (WIDTH+2)'(addend);
        wsum_ext = AW'(wsum);
        w_ov     = ovf(wsum_ext);
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            k         <= '0;
            xline     <= '0;
            acc       <= '0;
            desired_l <= '0;
            mu_l      <= '0;
            mode_l    <= '0;
            adapt_l   <= 1'b0;
            weights   <= '0;
            dout      <= '0;
            error     <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xline     <= {xline[TAPS-2:0], din};
                        desired_l <= desired;
                        mu_l      <= step_size;
                        mode_l    <= mode;
                        adapt_l   <= adapt_en;
                        acc       <= '0;
                        k         <= '0;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + AW'(prod);
                    if (k == KW'(TAPS-1)) begin
                        k     <= '0;
                        state <= ERR;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ERR: begin
                    dout      <= dout_n;
                    error     <= err_n;
                    out_valid <= 1'b1;
                    if (dout_ov || err_ov) sat_flag <= 1'b1;
                    state <= (adapt_l && mode_l != 2'd3) ? UPD : IDLE;
                end
                UPD: begin
                    weights[k] <= sat(wsum_ext);
                    if (w_ov || (mode_l == 2'd0 && g_ov) || (mode_l != 2'd2 && d_ov))
                        sat_flag <= 1'b1;
                    if (k == KW'(TAPS-1)) begin
                        k     <= '0;
                        state <= IDLE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adaptive_filter_seq.sv
// Bench for adaptive_filter_seq: per-sample arithmetic model plus cycle-by-cycle timing checks and directed literals.
module tb_adaptive_filter_seq;
    localparam int W = 16;
    localparam int F = 14;
    localparam int T = 4;

    logic               clk = 1'b0;
    logic               rstn = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [W-1:0]       din = '0, desired = '0, step_size = '0;
    logic [1:0]         mode = '0;
    logic               adapt_en = 1'b0;
    logic               out_valid;
    logic [W-1:0]       dout, error;
    logic [T-1:0][W-1:0] weights;
    logic               sat_flag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adaptive_filter_seq #(.WIDTH(W), .FRAC(F), .TAPS(T)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .desired(desired), .step_size(step_size), .mode(mode),
        .adapt_en(adapt_en), .out_valid(out_valid), .dout(dout), .error(error),
        .weights(weights), .sat_flag(sat_flag)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: whole-sample arithmetic on plain integers
    longint mw[T];
    longint mx[T];
    longint m_dout, m_err;
    bit     m_sat;

    function automatic longint msat(input longint v);
        if (v > 32767)  begin m_sat = 1'b1; return 32767;  end
        if (v < -32768) begin m_sat = 1'b1; return -32768; end
        return v;
    endfunction

    function automatic longint sgn(input longint v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < T; i++) begin mw[i] = 0; mx[i] = 0; end
        m_dout = 0; m_err = 0; m_sat = 1'b0;
    endtask

    task automatic model_accept(input longint d, input longint des, input longint mu,
                                input int md, input bit ad, output int rdy);
        longint acc, g;
        for (int i = T-1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = d;
        acc = 0;
        for (int i = 0; i < T; i++) acc += mw[i] * mx[i];
        m_dout = msat(acc >>> F);
        m_err  = msat(des - m_dout);
        rdy = T + 2;
        if (ad && md != 3) begin
            rdy = 2*T + 2;
            if (md == 0)      g = msat((mu * m_err) >>> F);
            else              g = sgn(m_err) * mu;
            for (int i = 0; i < T; i++) begin
                if (md == 2) mw[i] = msat(mw[i] + sgn(m_err) * sgn(mx[i]) * mu);
                else         mw[i] = msat(mw[i] + msat((g * mx[i]) >>> F));
            end
        end
    endtask

    int since = 0, rdy_at = 0, obs_ov = -1, obs_rdy = -1;
    bit busy = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            busy = 1'b0;
            model_reset();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_dout", $signed(dout), 0);
            chk("rst_sat", sat_flag, 0);
        end else begin
            bit exp_ov, exp_rdy;
            if (busy) since++;
            exp_ov  = busy && (since == T + 2);
            exp_rdy = !busy || (since >= rdy_at);
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, exp_rdy);
            if (busy && out_valid) obs_ov = since;
            if (busy && in_ready && obs_rdy < 0) obs_rdy = since;
            if (exp_ov) begin
                chk("dout", $signed(dout), m_dout);
                chk("error", $signed(error), m_err);
            end
            if (busy && since >= rdy_at) busy = 1'b0;
            if (!busy) begin
                for (int i = 0; i < T; i++)
                    chk($sformatf("w%0d", i), $signed(weights[i]), mw[i]);
                chk("sat_flag", sat_flag, m_sat);
                chk("dout_hold", $signed(dout), m_dout);
                chk("error_hold", $signed(error), m_err);
            end
            if (in_valid && in_ready) begin
                model_accept($signed(din), $signed(desired), longint'(step_size),
                             int'(mode), adapt_en, rdy_at);
                busy = 1'b1; since = 0; obs_ov = -1; obs_rdy = -1;
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [W-1:0] des, input logic [W-1:0] mu,
                        input logic [1:0] md, input logic ad);
        int n = 0;
        @(posedge clk); #2;
        while (!in_ready && n < 40) begin @(posedge clk); #2; n++; end
        chk("send_ready_wait", in_ready, 1);
        in_valid = 1'b1; din = d; desired = des; step_size = mu; mode = md; adapt_en = ad;
        @(posedge clk); #2;
        // Scramble inputs: the sample in flight must use its latched copies
        in_valid = 1'b0;
        din = 16'($urandom); desired = 16'($urandom); step_size = 16'($urandom);
        mode = 2'($urandom); adapt_en = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #2;
        while (!in_ready && n < 60) begin @(posedge clk); #2; n++; end
        chk("idle_wait", in_ready, 1);
        @(negedge clk); #1;
    endtask

    task automatic check_first_sample(input string tag);
        chk({tag, "_w0"}, $signed(weights[0]), 'sh0800);
        chk({tag, "_w1"}, $signed(weights[1]), 0);
        chk({tag, "_w3"}, $signed(weights[3]), 0);
        chk({tag, "_dout"}, $signed(dout), 0);
        chk({tag, "_error"}, $signed(error), 'sh1000);
        chk({tag, "_ov_cycle"}, obs_ov, 6);
        chk({tag, "_rdy_cycle"}, obs_rdy, 10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;
        @(negedge clk); #1;
        chk("init_in_ready", in_ready, 1);
        chk("init_out_valid", out_valid, 0);
        chk("init_weights", longint'(weights), 0);
        chk("init_dout", $signed(dout), 0);
        chk("init_error", $signed(error), 0);
        chk("init_sat", sat_flag, 0);

        send(16'h2000, 16'h1000, 16'h4000, 2'd0, 1'b1);
        wait_idle();
        check_first_sample("s1");

        send(16'h0000, 16'h1234, 16'h4000, 2'd0, 1'b0);
        wait_idle();
        chk("s2_w0", $signed(weights[0]), 'sh0800);
        chk("s2_error", $signed(error), 'sh1234);
        chk("s2_ov_cycle", obs_ov, 6);
        chk("s2_rdy_cycle", obs_rdy, 6);

        send(16'h0000, 16'h0000, 16'h4000, 2'd3, 1'b1);
        wait_idle();
        chk("s3_w0", $signed(weights[0]), 'sh0800);
        chk("s3_rdy_cycle", obs_rdy, 6);

        send(16'hF000, 16'h1000, 16'h0010, 2'd2, 1'b1);
        wait_idle();
        chk("s4_dout", $signed(dout), -'sh0200);
        chk("s4_error", $signed(error), 'sh1200);
        chk("s4_w0", $signed(weights[0]), 'sh07F0);
        chk("s4_w1", $signed(weights[1]), 0);
        chk("s4_w2", $signed(weights[2]), 0);
        chk("s4_w3", $signed(weights[3]), 'sh0010);

        send(16'h4000, 16'h0000, 16'h47F0, 2'd1, 1'b1);
        wait_idle();
        chk("s5_w0", $signed(weights[0]), -'sh4000);
        chk("s5_w1", $signed(weights[1]), 'sh11FC);
        chk("s5_sat", sat_flag, 0);

        send(16'h51FC, 16'h7FFF, 16'h4000, 2'd0, 1'b0);
        wait_idle();
        chk("s6_dout", $signed(dout), -'sh4000);
        chk("s6_error", $signed(error), 'sh7FFF);
        chk("s6_sat", sat_flag, 1);

        send(16'h0000, 16'h0000, 16'h4000, 2'd0, 1'b1);
        wait_idle();
        chk("s7_sat_sticky", sat_flag, 1);
        send(16'h4000, 16'h7FFF, 16'hFFFF, 2'd2, 1'b1);
        wait_idle();
        send(16'hC000, 16'h8000, 16'hFFFF, 2'd1, 1'b1);
        wait_idle();
        send(16'h1000, 16'h0800, 16'h2000, 2'd0, 1'b1);
        wait_idle();
        chk("s10_sat_sticky", sat_flag, 1);

        // Abort a sample partway through its weight update
        send(16'h0800, 16'h0000, 16'h2000, 2'd0, 1'b1);
        repeat (T + 3) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("abort_dout", $signed(dout), 0);
        chk("abort_error", $signed(error), 0);
        chk("abort_weights", longint'(weights), 0);
        chk("abort_sat", sat_flag, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk); @(negedge clk); #1 rstn = 1'b1;
        repeat (12) @(negedge clk);
        #1;

        send(16'h2000, 16'h1000, 16'h4000, 2'd0, 1'b1);
        wait_idle();
        check_first_sample("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adaptive_filter_seq.md
ADAPTIVE_FILTER_SEQ -- requirements
Module: adaptive_filter_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample/weight word width, two's complement.
REQ-002 SHALL have parameter FRAC, default 14, fractional bits of every Q-format value; FRAC < WIDTH.
REQ-003 SHALL have parameter TAPS, default 8, filter length; TAPS >= 2.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rstn  input  1  reset; one clock, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  din/desired/step_size/mode/adapt_en are valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port din  input  WIDTH  signed input sample.
REQ-009 SHALL have port desired  input  WIDTH  signed reference sample.
REQ-010 SHALL have port step_size  input  WIDTH  unsigned mu, Q(WIDTH-FRAC).FRAC.
REQ-011 SHALL have port mode  input  2  0=LMS, 1=sign-error, 2=sign-sign, 3=freeze.
REQ-012 SHALL have port adapt_en  input  1  0 = skip weight update for this sample.
REQ-013 SHALL have port out_valid  output  1  one-cycle pulse, dout/error updated.
REQ-014 SHALL have port dout  output  WIDTH  signed filter output, registered.
REQ-015 SHALL have port error  output  WIDTH  signed desired-minus-dout, registered.
REQ-016 SHALL have port weights  output  [TAPS-1:0][WIDTH-1:0]  signed current coefficients, registered.
REQ-017 SHALL have port sat_flag  output  1  sticky: any saturation event since reset.

Function
REQ-018 SHALL accept a sample on a rising edge where in_valid && in_ready; in_ready SHALL be 1 only in IDLE.
REQ-019 SHALL latch din, desired, step_size, mode, adapt_en on accept; later input changes SHALL not affect that sample.
REQ-020 SHALL shift the TAPS-deep delay line on accept only: x[0]=din, x[k]=old x[k-1]; oldest sample discarded.
REQ-021 SHALL implement FSM IDLE -> MAC (TAPS cycles, one multiply-accumulate per cycle, k=0..TAPS-1) -> ERR (1 cycle) -> UPD (TAPS cycles, one weight per cycle) -> IDLE.
REQ-022 ERR SHALL go to IDLE instead of UPD when latched adapt_en=0 or mode=3.
REQ-023 Accumulator SHALL be 2*WIDTH+ceil(log2(TAPS)) bits, full-precision products w[k]*x[k], no intermediate saturation.
REQ-024 dout SHALL equal acc >>> FRAC (arithmetic shift, truncation) saturated to WIDTH signed range.
REQ-025 error SHALL equal desired - dout computed in WIDTH+1 bits, saturated to WIDTH.
REQ-026 dout and error SHALL be registered at end of ERR; out_valid SHALL be 1 exactly the following cycle (accept edge + TAPS+2 cycles).
REQ-027 Mode 0: g = sat((mu*e) >>> FRAC); w[k] += sat((g*x[k]) >>> FRAC).
REQ-028 Mode 1: g = +mu if e>0, -mu if e<0, 0 if e=0; w[k] += sat((g*x[k]) >>> FRAC).
REQ-029 Mode 2: w[k] += sign(e)*sign(x[k])*mu, sign(0)=0.
REQ-030 Every weight sum SHALL saturate to WIDTH signed range, never wrap.
REQ-031 UPD SHALL use the error of the current sample and the delay-line contents used in MAC.
REQ-032 sat_flag SHALL set on any saturation in REQ-024/025/027-030 and hold until reset.
REQ-033 Throughput SHALL be one sample per 2*TAPS+2 cycles (adapting) or TAPS+2 cycles (not adapting); in_ready SHALL rise the cycle after the last UPD cycle or after ERR.

Reset
REQ-034 rstn=0 SHALL asynchronously clear FSM to IDLE, delay line, accumulator, weights, dout, error, out_valid, sat_flag to 0; in_ready=1 while in IDLE.
REQ-035 Reset mid-MAC/ERR/UPD SHALL abandon the sample; no out_valid for it after release.

Verification (WIDTH=16, FRAC=14, TAPS=4)
REQ-036 Reset release -> in_ready=1, out_valid=0, weights all 0, dout=0, error=0, sat_flag=0.
REQ-037 Accept din=0x2000, desired=0x1000, mu=0x4000, mode 0, adapt_en=1 -> out_valid 6 cycles after accept, dout=0, error=0x1000; after UPD w[0]=0x0800, w[1..3]=0; in_ready returns 10 cycles after accept.
REQ-038 Weights preloaded via adaptation to make dout=-0x4000, desired=0x7FFF -> error=0x7FFF (saturated), sat_flag=1 and stays 1.
REQ-039 Mode 2, mu=0x0010, x[0]=-0x1000, error>0 -> w[0] decreases by exactly 0x0010; taps with x[k]=0 unchanged.
REQ-040 adapt_en=0 (or mode=3) -> weights unchanged, out_valid at +6, in_ready high again at +6.
REQ-041 rstn pulsed low during UPD of second sample -> all outputs 0 immediately, no out_valid after release, next accepted sample behaves as REQ-037.
